// File: rtl/lti_serial_ss.sv
// Time-multiplexed delta-operator state-space SISO controller: one MAC walks
// [A B; C D] row by row, then all states advance together and y is quantized.
module lti_serial_ss #(
  parameter int NS  = 4,
  parameter int IW  = 16,
  parameter int OW  = 16,
  parameter int CW  = 16,
  parameter int SW  = 25,
  parameter int CF  = 15,
  parameter int DEL = 10,
  parameter int AW  = 7,
  parameter int RW  = SW + CW + 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [IW-1:0] sig_in1,
  input  logic                 ce_in,
  output logic signed [OW-1:0] sig_out1,
  output logic                 ce_out,
  output logic                 busy,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  input  logic                 coef_swap,
  output logic                 overrun,
  output logic                 sat_flag
);
  localparam int NC  = (NS + 1) * (NS + 1);
  localparam int IXW = $clog2(NC);
  localparam int PW  = CW + SW;
  localparam logic [3:0]  LAST = 4'(NS);
  localparam logic [AW:0] NC_A = (AW + 1)'(NC);

  typedef enum logic [2:0] {IDLE, LOAD, MAC, UPDATE, DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            r_q, r_d, c_q, c_d;
  logic [IXW-1:0]        ca_q, ca_d;
  logic signed [SW-1:0]  u_q, u_d;
  logic signed [SW-1:0]  x_q [NS];
  logic signed [SW-1:0]  x_d [NS];
  logic signed [RW-1:0]  x_long_q [NS];
  logic signed [RW-1:0]  x_long_d [NS];
  logic signed [RW-1:0]  dx_q [NS];
  logic signed [RW-1:0]  dx_d [NS];
  logic signed [RW-1:0]  acc_q, acc_d, y_acc_q, y_acc_d;
  logic signed [OW-1:0]  out_q, out_d;
  logic                  ce_out_q, ce_out_d, busy_q, busy_d;
  logic                  overrun_q, overrun_d, sat_q, sat_d;
  logic                  swap_q, swap_d, bsel_q, bsel_d;
  logic signed [CW-1:0]  bank_q [2][NC];
  logic signed [CW-1:0]  bank_d [2][NC];

  logic signed [SW-1:0]  opnd;
  logic signed [PW-1:0]  coef_x, opnd_x, prod;
  logic signed [RW-1:0]  acc_base, acc_sum;
  logic                  clip;

  function automatic logic signed [SW-1:0] quant_sw(input logic signed [RW-1:0] v,
                                                    output logic clp);
    logic signed [RW-1:0] s;
    s   = v >>> CF;
    clp = (s[RW-1:SW-1] != {(RW-SW+1){s[RW-1]}});
    if (clp) return s[RW-1] ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
    return s[SW-1:0];
  endfunction

  function automatic logic signed [OW-1:0] quant_ow(input logic signed [RW-1:0] v,
                                                    output logic clp);
    logic signed [RW-1:0] s;
    s   = v >>> CF;
    clp = (s[RW-1:OW-1] != {(RW-OW+1){s[RW-1]}});
    if (clp) return s[RW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    return s[OW-1:0];
  endfunction

  // Datapath: column NS feeds u, all other columns feed the quantized state.
  always_comb begin
    opnd = u_q;
    for (int j = 0; j < NS; j++)
      if (c_q == 4'(j)) opnd = x_q[j];
    coef_x   = {{SW{bank_q[bsel_q][ca_q][CW-1]}}, bank_q[bsel_q][ca_q]};
    opnd_x   = {{CW{opnd[SW-1]}}, opnd};
    prod     = coef_x * opnd_x;
    acc_base = (c_q == '0) ? '0 : acc_q;
    acc_sum  = acc_base + {{(RW-PW){prod[PW-1]}}, prod};
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    ca_d      = ca_q;
    u_d       = u_q;
    x_d       = x_q;
    x_long_d  = x_long_q;
    dx_d      = dx_q;
    acc_d     = acc_q;
    y_acc_d   = y_acc_q;
    out_d     = out_q;
    ce_out_d  = 1'b0;
    busy_d    = busy_q;
    bsel_d    = bsel_q;
    bank_d    = bank_q;
    clip      = 1'b0;
    sat_d     = sat_q;
    overrun_d = overrun_q | (ce_in & (state_q != IDLE));
    swap_d    = coef_swap | (swap_q & (state_q != LOAD));
    // Writes always target the bank that is shadow before any toggle this cycle.
    if (coef_we && ({1'b0, coef_addr} < NC_A))
      bank_d[~bsel_q][coef_addr[IXW-1:0]] = coef_wdata;
    case (state_q)
      IDLE: if (ce_in) begin
        state_d = LOAD;
        busy_d  = 1'b1;
      end
      LOAD: begin
        u_d = SW'(sig_in1);
        for (int j = 0; j < NS; j++) begin
          x_d[j] = quant_sw(x_long_q[j], clip);
          if (clip) sat_d = 1'b1;
        end
        if (swap_q) bsel_d = ~bsel_q;
        r_d     = '0;
        c_d     = '0;
        ca_d    = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_sum;
        ca_d  = ca_q + 1'b1;
        if (c_q == LAST) begin
          c_d = '0;
          r_d = r_q + 1'b1;
          if (r_q == LAST) begin
            y_acc_d = acc_sum;
            ca_d    = '0;
            state_d = UPDATE;
          end else begin
            for (int j = 0; j < NS; j++)
              if (r_q == 4'(j)) dx_d[j] = acc_sum;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      UPDATE: begin
        for (int j = 0; j < NS; j++)
          x_long_d[j] = x_long_q[j] + (dx_q[j] >>> DEL);
        out_d = quant_ow(y_acc_q, clip);
        if (clip) sat_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        ce_out_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      c_q       <= '0;
      ca_q      <= '0;
      u_q       <= '0;
      acc_q     <= '0;
      y_acc_q   <= '0;
      out_q     <= '0;
      ce_out_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      sat_q     <= 1'b0;
      swap_q    <= 1'b0;
      bsel_q    <= 1'b0;
      for (int j = 0; j < NS; j++) begin
        x_q[j]      <= '0;
        x_long_q[j] <= '0;
        dx_q[j]     <= '0;
      end
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NC; i++) bank_q[b][i] <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      ca_q      <= ca_d;
      u_q       <= u_d;
      acc_q     <= acc_d;
      y_acc_q   <= y_acc_d;
      out_q     <= out_d;
      ce_out_q  <= ce_out_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      sat_q     <= sat_d;
      swap_q    <= swap_d;
      bsel_q    <= bsel_d;
      x_q       <= x_d;
      x_long_q  <= x_long_d;
      dx_q      <= dx_d;
      bank_q    <= bank_d;
    end
  end

  assign sig_out1 = out_q;
  assign ce_out   = ce_out_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
  assign sat_flag = sat_q;
endmodule
